// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg
//   Shared definitions for the FIFO-draining UART transmitter:
//   - tx_state_e     : transmitter FSM states (PARITY is reachable only with
//                      FIFO_UART_TX_PARITY_EN defined)
//   - STOP_BITS      : stop bits per frame
//   - DEFAULT_CLKS_PER_BIT : 100 MHz / 115200 baud
//   - baud_cnt_w()   : width of the per-bit baud counter
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_PARITY
    } tx_state_e;

    localparam int unsigned STOP_BITS            = 1;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    function automatic int unsigned baud_cnt_w(input int unsigned clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// baud_tick_gen
//   Free-running bit-period counter with synchronous clear.
//   Ports:
//     clk      in  system clock, rising edge
//     rst      in  synchronous active-high reset
//     clr      in  synchronous clear; counter restarts at 0 next cycle
//     tick     out high on the last cycle of each CLKS_PER_BIT period
//     pre_tick out high on the cycle before tick
module baud_tick_gen
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_W        = baud_cnt_w(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic pre_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
        tick     = (cnt_q == LAST);
        pre_tick = (cnt_q == PRE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains a byte FIFO onto a UART line: pops one byte whenever the FIFO is
//   non-empty and the line is idle, then sends it LSB first as 8N1.
//   Optional macro FIFO_UART_TX_PARITY_EN inserts an even-parity bit between
//   the data bits and the stop bit (11-bit frame).
//   Ports:
//     clk         in  system clock, rising edge
//     rst         in  synchronous active-high reset
//     buf_empty   in  FIFO empty flag
//     buf_out     in  FIFO read data, valid the cycle after rd_en
//     rd_en       out one-cycle pop strobe (registered)
//     tx          out serial line, idle high (registered)
//     tx_busy     out high whenever the FSM is not idle (registered)
//     tx_done     out one-cycle pulse on the last stop-bit cycle (registered)
//     frame_count out frames completed since reset, wraps (registered)
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buf_empty,
    input  logic [DATA_W-1:0] buf_out,
    output logic              rd_en,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [CNT_W-1:0]  frame_count
);

    localparam int unsigned    IDX_W     = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              tx_q, tx_d;
    logic              rd_en_q, rd_en_d;
    logic              tx_busy_q, tx_busy_d;
    logic              tx_done_q, tx_done_d;
    logic [CNT_W-1:0]  frame_count_q, frame_count_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic baud_tick;
    logic baud_pre_tick;
    logic baud_clr;

    assign baud_clr = (state_q == ST_LOAD);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (baud_clr),
        .tick     (baud_tick),
        .pre_tick (baud_pre_tick)
    );

    // Outputs are registered, so they are derived from the next state:
    // the flop then shows the value that belongs to the state being entered.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_idx_d     = bit_idx_q;
        frame_count_d = frame_count_q;
        tx_done_d     = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d      = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!buf_empty) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shreg_d   = buf_out;
                bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d  = ^buf_out;
`endif
                state_d   = ST_START;
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // pre_tick lets the registered done pulse land on the
                // final stop-bit cycle rather than one cycle after it.
                if (baud_pre_tick && (bit_idx_q == STOP_LAST)) begin
                    tx_done_d     = 1'b1;
                    frame_count_d = frame_count_q + CNT_W'(1);
                end
                if (baud_tick) begin
                    if (bit_idx_q == STOP_LAST) begin
                        bit_idx_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_en_d   = (state_d == ST_POP);
        tx_busy_d = (state_d != ST_IDLE);

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bit_idx_q     <= '0;
            tx_q          <= 1'b1;
            rd_en_q       <= 1'b0;
            tx_busy_q     <= 1'b0;
            tx_done_q     <= 1'b0;
            frame_count_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_idx_q     <= bit_idx_d;
            tx_q          <= tx_d;
            rd_en_q       <= rd_en_d;
            tx_busy_q     <= tx_busy_d;
            tx_done_q     <= tx_done_d;
            frame_count_q <= frame_count_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign rd_en       = rd_en_q;
    assign tx          = tx_q;
    assign tx_busy     = tx_busy_q;
    assign tx_done     = tx_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a 64-deep FIFO
//   model with one-cycle read latency. Honours FIFO_UART_TX_PARITY_EN.
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        buf_empty;
    logic [7:0]  buf_out = '0;
    logic        rd_en;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .buf_empty   (buf_empty),
        .buf_out     (buf_out),
        .rd_en       (rd_en),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .frame_count (frame_count)
    );

    // FIFO model
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] mem [64];
    logic [5:0] wp = '0;
    logic [5:0] rp = '0;
    logic [6:0] cnt = '0;
    logic       do_rd;

    assign buf_empty = (cnt == 7'd0);
    assign do_rd     = rd_en && (cnt != 7'd0);

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= wr_data;
            wp      <= wp + 6'd1;
        end
        if (do_rd) begin
            buf_out <= mem[rp];
            rp      <= rp + 6'd1;
        end
        cnt <= cnt + {6'd0, wr_en} - {6'd0, do_rd};
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp_frames = 0;
    int rd_pulses = 0;
    logic prev_rd = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every pop must see a non-empty FIFO and never repeat on consecutive cycles.
    always @(negedge clk) begin
        if (rd_en === 1'b1) begin
            rd_pulses = rd_pulses + 1;
            check_eq("rd_nonempty", buf_empty, 0);
            check_eq("rd_single", prev_rd, 0);
        end
        prev_rd <= rd_en;
    end

    function automatic logic [63:0] frame_vec(input logic [7:0] b);
        logic [FRAME_BITS-1:0] bits;
        logic [63:0] v;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef FIFO_UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        v = '0;
        for (int c = 0; c < int'(FRAME_CYC); c++) v[c] = bits[c / CPB];
        return v;
    endfunction

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_rd_en", rd_en, 0);
        end
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_done", tx_done, 0);
        check_eq("rst_fcount", frame_count, 0);
        rst = 1'b0;
        exp_frames = 0;
    endtask

    // Counts tx-high cycles until the first start-bit cycle (seen at a negedge).
    task automatic wait_start(output logic found, output int gap);
        found = 1'b0;
        gap   = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            gap++;
        end
        check_eq("start_seen", found, 1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input int gap_exp, output logic [63:0] txv);
        logic found;
        int gap;
        logic [63:0] donev, busyv, all_busy;
        txv = '0; donev = '0; busyv = '0; all_busy = '0;
        wait_start(found, gap);
        if (!found) return;
        if (gap_exp >= 0) check_eq("gap", gap, gap_exp);
        for (int c = 0; c < int'(FRAME_CYC); c++) begin
            if (c != 0) @(negedge clk);
            txv[c]      = tx;
            donev[c]    = tx_done;
            busyv[c]    = tx_busy;
            all_busy[c] = 1'b1;
        end
        exp_frames++;
        check_eq("frame", txv, frame_vec(b));
        check_eq("done_pulse", donev, 64'd1 << (FRAME_CYC - 1));
        check_eq("busy", busyv, all_busy);
        check_eq("fcount", frame_count, exp_frames);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        logic any_low, any_rd, any_busy, any_done, found;
        int gap, p0;

        // Idle with empty FIFO
        do_reset();
        any_low = 0; any_rd = 0; any_busy = 0; any_done = 0;
        repeat (50) begin
            @(negedge clk);
            any_low  |= ~tx;
            any_rd   |= rd_en;
            any_busy |= tx_busy;
            any_done |= tx_done;
        end
        check_eq("idle_tx_low", any_low, 0);
        check_eq("idle_rd_en", any_rd, 0);
        check_eq("idle_busy", any_busy, 0);
        check_eq("idle_done", any_done, 0);
        check_eq("idle_fcount", frame_count, 0);

        // Single byte 0x32: pop latency and exact frame
        push(8'h32);
        @(negedge clk); check_eq("rd_lat0", rd_en, 0);
        @(negedge clk); check_eq("rd_lat1", rd_en, 1);
        @(negedge clk); check_eq("rd_lat2", rd_en, 0);
        rx_frame(8'h32, 0, v);
`ifdef FIFO_UART_TX_PARITY_EN
        check_eq("frame32_hand", v, 64'h0FF_00FF_00F00);
`else
        check_eq("frame32_hand", v, 64'h00_F00F_F00F00);
`endif
        @(negedge clk);
        check_eq("back_idle_busy", tx_busy, 0);
        check_eq("back_idle_tx", tx, 1);

        // Back-to-back frames
        do_reset();
        p0 = rd_pulses;
        push(8'h32);
        push(8'h1D);
        push(8'h3D);
        rx_frame(8'h32, -1, v);
`ifdef FIFO_UART_TX_PARITY_EN
        check_eq("par32", v[39:36], 4'hF);
`endif
        rx_frame(8'h1D, 3, v);
`ifdef FIFO_UART_TX_PARITY_EN
        check_eq("par1D", v[39:36], 4'h0);
        check_eq("frame1D_len", v[43:40], 4'hF);
`endif
        rx_frame(8'h3D, 3, v);
        @(negedge clk);
        check_eq("b2b_empty", buf_empty, 1);
        check_eq("b2b_fcount", frame_count, 3);
        check_eq("b2b_pops", rd_pulses - p0, 3);

        // Reset during data bit 3 of 0xA5
        do_reset();
        push(8'hA5);
        push(8'h3C);
        wait_start(found, gap);
        repeat (17) @(negedge clk);
        check_eq("a5_bit3", tx, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_tx", tx, 1);
        check_eq("mid_rst_busy", tx_busy, 0);
        check_eq("mid_rst_fcount", frame_count, 0);
        repeat (3) begin
            @(negedge clk);
            check_eq("mid_rst_rd_en", rd_en, 0);
        end
        rst = 1'b0;
        exp_frames = 0;
        rx_frame(8'h3C, -1, v);
        @(negedge clk);
        check_eq("post_rst_empty", buf_empty, 1);

        // 63 bytes streamed through
        do_reset();
        p0 = rd_pulses;
        fork
            begin
                for (int i = 0; i < 63; i++) push(8'(i));
            end
            begin
                for (int i = 0; i < 63; i++) rx_frame(8'(i), (i == 0) ? -1 : 3, v);
            end
        join
        @(negedge clk);
        check_eq("burst_fcount", frame_count, 63);
        check_eq("burst_pops", rd_pulses - p0, 63);
        check_eq("burst_empty", buf_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
